// File: rtl/tristate_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tristate_bus_arbiter
// Purpose  : Round-robin arbiter producing one-hot bufif1 enables for a shared
//            tristate bus, with bounded ownership time.
//            Define TRISTATE_BUS_TURNAROUND_EN to add a dead cycle between
//            consecutive owners.
// Revision : 1.0 - initial release
// ============================================================================
module tristate_bus_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int HOLD_MAX  = 4,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] drv_en,
    output logic [IDX_W-1:0]     gnt_id,
    output logic                 busy,
    output logic                 handoff
);

    localparam int              HC_W       = $clog2(HOLD_MAX + 1);
    localparam logic [HC_W-1:0] c_hold_max = HC_W'(HOLD_MAX);
    localparam logic [HC_W-1:0] c_hold_one = HC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1
`ifdef TRISTATE_BUS_TURNAROUND_EN
        ,S_TURN = 2'd2
`endif
    } state_t;

    state_t                 state_q,    state_d;
    logic [IDX_W-1:0]       rr_ptr_q,   rr_ptr_d;
    logic [HC_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic [N_MASTERS-1:0]   drv_en_q,   drv_en_d;
    logic [IDX_W-1:0]       gnt_id_q,   gnt_id_d;
    logic                   busy_q,     busy_d;
    logic                   handoff_q,  handoff_d;

    logic                   w_others;
    logic                   w_release;
    logic [IDX_W-1:0]       w_next_ptr;
    logic [IDX_W-1:0]       w_pick_ptr;
    logic [IDX_W-1:0]       w_win;
    logic [N_MASTERS-1:0]   w_win_onehot;
    logic                   w_grant;
    logic                   w_drop;

    // First requester found scanning upward from ptr, wrapping modulo N_MASTERS.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_MASTERS-1:0] r,
        input logic [IDX_W-1:0]     ptr
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = (int'(ptr) + k) % N_MASTERS;
            if (!found && r[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_others     = |(req & ~drv_en_q);
    assign w_release    = !req[gnt_id_q] || ((hold_cnt_q == c_hold_max) && w_others);
    assign w_next_ptr   = IDX_W'((int'(gnt_id_q) + 1) % N_MASTERS);
    // A direct handoff out of OWN must already see the demoted previous owner.
    assign w_pick_ptr   = (state_q == S_OWN) ? w_next_ptr : rr_ptr_q;
    assign w_win        = rr_pick(req, w_pick_ptr);
    assign w_win_onehot = N_MASTERS'(1) << w_win;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        drv_en_d   = drv_en_q;
        gnt_id_d   = gnt_id_q;
        handoff_d  = 1'b0;
        w_grant    = 1'b0;
        w_drop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                w_grant = |req;
            end
            S_OWN: begin
                if (w_release) begin
                    rr_ptr_d = w_next_ptr;
`ifdef TRISTATE_BUS_TURNAROUND_EN
                    state_d = S_TURN;
                    w_drop  = 1'b1;
`else
                    if (|req) begin
                        w_grant = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        w_drop  = 1'b1;
                    end
`endif
                end else if (hold_cnt_q != c_hold_max) begin
                    hold_cnt_d = hold_cnt_q + c_hold_one;
                end
            end
`ifdef TRISTATE_BUS_TURNAROUND_EN
            S_TURN: begin
                if (|req) begin
                    w_grant = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    w_drop  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                w_drop  = 1'b1;
            end
        endcase

        if (w_grant) begin
            state_d    = S_OWN;
            drv_en_d   = w_win_onehot;
            gnt_id_d   = w_win;
            hold_cnt_d = c_hold_one;
            handoff_d  = 1'b1;
        end else if (w_drop) begin
            drv_en_d   = '0;
            hold_cnt_d = '0;
        end

        busy_d = |drv_en_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            drv_en_q   <= '0;
            gnt_id_q   <= '0;
            busy_q     <= 1'b0;
            handoff_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            drv_en_q   <= drv_en_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            handoff_q  <= handoff_d;
        end
    end

    assign drv_en  = drv_en_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign handoff = handoff_q;

endmodule
`default_nettype wire
